// File: rtl/div_bus_adapter.sv
// Bus front/back end for the restoring divider: gathers operands from a narrow
// valid/ready bus, runs the divider handshake and streams quotient/remainder out.
module div_bus_adapter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BUS_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BUS_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              div_start,
  input  logic              div_ready,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned BEATS = DATA_W / BUS_W;
  localparam int unsigned CW    = (2 * BEATS > 1) ? $clog2(2 * BEATS) : 1;
  localparam logic [CW-1:0] LAST_A   = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_ALL = CW'(2 * BEATS - 1);

  localparam logic [2:0] S_RX_A  = 3'd0;
  localparam logic [2:0] S_RX_B  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  // Operands packed {divisor, dividend} and results {remainder, quotient} so the
  // beat counter doubles as a slice index across both halves.
  logic [2*DATA_W-1:0] ops_q, ops_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ops_d     = ops_q;
    res_d     = res_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;

    case (state_q)
      S_RX_A, S_RX_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ops_d[cnt_q*BUS_W +: BUS_W] = in_data;
          cnt_d = cnt_q + CW'(1);
          if (state_q == S_RX_A && cnt_q == LAST_A) begin
            state_d = S_RX_B;
          end else if (state_q == S_RX_B && cnt_q == LAST_ALL) begin
            cnt_d = '0;
            // Divide-by-zero is answered locally without touching the divider.
            if (ops_d[2*DATA_W-1:DATA_W] == '0) begin
              res_d   = {ops_d[DATA_W-1:0], {DATA_W{1'b1}}};
              err_d   = 1'b1;
              state_d = S_TX;
            end else begin
              state_d = S_START;
            end
          end
        end
      end
      S_START: begin
        if (div_ready) begin
          div_start = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!div_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (div_ready) begin
          res_d   = {div_remainder, div_quotient};
          err_d   = 1'b0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        out_valid = 1'b1;
        out_data  = res_q[cnt_q*BUS_W +: BUS_W];
        out_last  = (cnt_q == LAST_ALL);
        if (out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ALL) begin
            cnt_d   = '0;
            state_d = S_RX_A;
          end
        end
      end
      default: begin
        state_d = S_RX_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX_A;
      cnt_q   <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign div_dividend = ops_q[DATA_W-1:0];
  assign div_divisor  = ops_q[2*DATA_W-1:DATA_W];
  assign out_err      = (state_q == S_TX) && err_q;
  assign busy         = (state_q != S_RX_A) || (cnt_q != '0);

endmodule

// File: tb/tb_div_bus_adapter.sv
// Scoreboard bench for div_bus_adapter with a behavioural divider on the far side.
module tb_div_bus_adapter;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          div_start;
  logic          div_ready = 1'b1;
  logic [DW-1:0] div_dividend, div_divisor;
  logic [DW-1:0] div_quotient = '0, div_remainder = '0;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last, out_err, busy;

  div_bus_adapter #(.DATA_W(DW), .BUS_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .div_start(div_start), .div_ready(div_ready), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BW-1:0] d; logic last; logic err; } beat_t;
  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } op_t;

  beat_t exp_q[$];
  op_t   op_q[$];
  int    total = 0;
  int    bad = 0;

  bit    exp_ready = 1'b1;
  int    in_cnt = 0;
  int    out_k = 0;
  int    starts = 0;
  bit    rand_ready = 1'b0;
  bit    stall_req = 1'b0;
  int    lat_override = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected progress at %0t", name, $time);
  endfunction

  // Divider stand-in: garbage on its result bus while busy, true a/b when done.
  initial begin
    logic          st;
    logic [DW-1:0] la, lb;
    int            dcnt;
    dcnt = 0; la = '0; lb = '0;
    forever begin
      @(negedge clk);
      st = rst_n && div_start && div_ready;
      if (st) begin la = div_dividend; lb = div_divisor; end
      @(posedge clk); #1;
      if (!rst_n) begin
        div_ready = 1'b1; dcnt = 0;
      end else if (dcnt != 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_quotient  = (lb == 0) ? '1 : la / lb;
          div_remainder = (lb == 0) ? la : la % lb;
          div_ready     = 1'b1;
        end
      end else if (st) begin
        div_ready     = 1'b0;
        div_quotient  = DW'($urandom);
        div_remainder = DW'($urandom);
        dcnt = (lat_override != 0) ? lat_override : int'($urandom_range(1, 6));
      end
    end
  end

  // Monitor: handshake model plus scoreboard pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ready = 1'b1; in_cnt = 0; out_k = 0; starts = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!(exp_ready && in_cnt == 0)));
      if (div_start) begin
        chk("div_start_allowed", 32'(!exp_ready && op_q.size() > 0 && starts == 0 &&
                                     op_q[0].b != 0), 32'd1);
        if (op_q.size() > 0) begin
          chk("div_dividend", 32'(div_dividend), 32'(op_q[0].a));
          chk("div_divisor", 32'(div_divisor), 32'(op_q[0].b));
        end
        starts++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_last", 32'(out_last), 32'(exp_q[0].last));
          chk("out_err", 32'(out_err), 32'(exp_q[0].err));
          if (out_ready) begin
            if (exp_q[0].last) begin
              if (op_q.size() > 0) begin
                chk("div_start_count", 32'(starts), 32'(op_q[0].b != 0));
                void'(op_q.pop_front());
              end
              out_k = 0; starts = 0; exp_ready = 1'b1; in_cnt = 0;
            end else begin
              out_k++;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        in_cnt++;
        if (in_cnt == 2 * NB) exp_ready = 1'b0;
      end
    end
  end

  // Sink: either always ready, random, or a 3-cycle stall on the second beat.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_req && out_valid && out_k == 1) begin
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        stall_req = 1'b0;
        out_ready = 1'b1;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic push_expect(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] res;
    beat_t bt;
    op_t   op;
    if (b == 0) res = {a, {DW{1'b1}}};
    else        res = {DW'(a % b), DW'(a / b)};
    for (int k = 0; k < 2 * NB; k++) begin
      bt.d    = res[k*BW +: BW];
      bt.last = (k == 2 * NB - 1);
      bt.err  = (b == 0);
      exp_q.push_back(bt);
    end
    op.a = a; op.b = b;
    op_q.push_back(op);
  endtask

  task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit gaps);
    logic [2*DW-1:0] ops;
    bit acc;
    ops = {b, a};
    push_expect(a, b);
    for (int k = 0; k < 2 * NB; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = BW'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = ops[k*BW +: BW];
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) fail("in_accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) fail("drain");
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    send_op(8'd100, 8'd7, 1'b0);             // E,0,2,0
    drain();
    send_op(8'h25, 8'd0, 1'b0);              // F,F,5,2 with err
    drain();
    stall_req = 1'b1;
    send_op(8'd100, 8'd7, 1'b0);             // sink stalls on beat 2
    drain();
    send_op(8'd77, 8'd5, 1'b0);              // back to back: in_valid stays high
    send_op(8'd200, 8'd13, 1'b0);
    send_op(8'd9, 8'd0, 1'b0);
    drain();

    lat_override = 20;                       // park the adapter waiting on the divider
    send_op(8'd100, 8'd7, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    op_q.delete();
    lat_override = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(8'd200, 8'd9, 1'b0);             // 22 r 2 -> 6,1,2,0
    drain();

    send_op(8'd255, 8'd1, 1'b1);             // F,F,0,0 with input gaps
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] ra, rb;
      ra = DW'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 255));
      send_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
